adder_sum_accumulator: RTL
==========================

// Module: adder_sum_accumulator
// PURPOSE
//  Downstream consumer of the 8-bit adder stage's registered 9-bit sum.
//  Re-times the adder clock-enable into a sample-valid strobe and accumulates
//  BLOCK_LEN consecutive sums into a wide total.
//  Presents each completed total on a valid/ready output handshake for the
//  VIO / probe readback.
// PARAMETERS
//  SUM_W      9   width of incoming adder sum
//  ACC_W      16  accumulator / total width
//  BLOCK_LEN  8   samples per block (>=1)
//  ADD_LAT    1   adder pipeline latency in cycles, from CE to sum valid (>=1)
// PORTS
//  clock      in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  ce_in      in   1          same CE driven into the adder
//  sum_in     in   SUM_W      adder output S
//  start      in   1          begin a new block (level, sampled in IDLE/HOLD)
//  out_valid  out  1          total available
//  out_ready  in   1          consumer accepts total
//  acc_out    out  ACC_W      block total
//  overflow   out  1          block total wrapped past 2^ACC_W
//  busy       out  1          state == ACCUM
//  drop_cnt   out  8          samples discarded outside ACCUM, saturating
//  min_out    out  SUM_W      block minimum (see CONFIGURATION)
//  max_out    out  SUM_W      block maximum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release) clears everything:
//    - outputs: all 0, state IDLE;
//    - internal: delay line, counters, accumulator.
//  - sample_valid = ce_in delayed ADD_LAT cycles; aligned with sum_in.
//  - IDLE: start=1 -> ACCUM next cycle; acc, count, overflow, min/max cleared.
//  - ACCUM:
//    - each sample_valid: acc <= acc + zero-extended sum_in, modulo 2^ACC_W;
//      carry out sets overflow (sticky for the block); count++.
//    - the BLOCK_LEN-th sample is added and the FSM goes to HOLD on the same
//      edge; out_valid=1 in the following cycle.
//    - start is ignored in ACCUM.
//  - HOLD:
//    - out_valid=1; acc_out, overflow, min_out, max_out held stable.
//    - transfer on out_valid && out_ready.
//    - after transfer: start=1 -> ACCUM (clears); start=0 -> IDLE.
//    - out_valid never drops without a transfer.
//  - sample_valid in IDLE/HOLD: sample discarded; drop_cnt++ (saturates at 255).
//    drop_cnt is cleared only by reset.
//  - acc_out shows the running sum during ACCUM; it is only meaningful when
//    out_valid=1.
//  - Reset mid-block: the partial block is discarded. No out_valid is produced.
// CONFIGURATION
//  - MINMAX_TRACK_EN defined: min_out/max_out track the min and max sum_in of
//    accepted samples in the block.
//    - min is initialised to all-1s, max to 0 on block start;
//    - both are held in HOLD.
//  - MINMAX_TRACK_EN undefined: no tracking registers; min_out=max_out=0 always.
// STRUCTURE
//  - Package adder_acc_pkg: state enum {IDLE, ACCUM, HOLD}; default width
//    constants SUM_W_D=9, ACC_W_D=16.
//  - Sub-module ce_delay_line (param DEPTH=ADD_LAT):
//    - shift register ce_in -> sample_valid;
//    - async reset to 0.
// TESTING (defaults unless stated)
//  - Reset check:
//    - stimulus: assert reset mid-ACCUM after 3 samples; release; start;
//      8 x sum 1.
//    - response: all outputs 0 during reset; then acc_out=8; no earlier
//      out_valid.
//  - Basic block:
//    - stimulus: start; 8 x sum 0x1FF with CE every cycle.
//    - response: acc_out=0x0FF8, overflow=0; out_valid=1 exactly ADD_LAT+1
//      cycles after the 8th CE.
//  - Backpressure:
//    - stimulus: out_ready=0 for 5 cycles while 3 more CEs arrive.
//    - response: acc_out stays 0x0FF8; drop_cnt=3; transfer on the first
//      cycle out_ready=1.
//  - Overflow:
//    - stimulus: ACC_W=12, BLOCK_LEN=16; 16 x 0x1FF.
//    - response: acc_out=0xFF0, overflow=1.
//  - Back-to-back blocks:
//    - stimulus: start held high; sums 1..8, then 9..16.
//    - response: totals 36, then 100; no IDLE cycle between the blocks.
//  - MINMAX_TRACK_EN:
//    - stimulus: sums {5, 0x100, 3, 7, 7, 2, 0x1FF, 9}.
//    - response: min_out=2, max_out=0x1FF.
//    - without the macro: both outputs 0.

Source files
------------

// File: rtl/adder_sum_accumulator_pkg.sv
// Shared types and default widths for the adder-sum accumulator slice:
// FSM state encoding plus a saturating counter helper.
package adder_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    localparam int SUM_W_D = 9;
    localparam int ACC_W_D = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// Block-total readback handshake: the accumulator drives the total and its
// side information, the consumer returns out_ready.
interface adder_sum_accumulator_if
    import adder_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_D,
    parameter int ACC_W = ACC_W_D
) ();

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic [SUM_W-1:0] min_out;
    logic [SUM_W-1:0] max_out;

    modport master (
        output out_valid,
        output acc_out,
        output overflow,
        output min_out,
        output max_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  acc_out,
        input  overflow,
        input  min_out,
        input  max_out,
        output out_ready
    );

endinterface

// File: rtl/adder_sum_accumulator_ce_delay_line.sv
// Re-times the adder clock-enable by DEPTH cycles so the resulting strobe
// lines up with the adder's registered sum.
module ce_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic ce_i,
    output logic sample_valid_o
);

    logic [DEPTH-1:0] shift_q;

    // CE shift register, oldest stage is the aligned sample strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= {DEPTH{1'b0}};
        end else begin
            shift_q[0] <= ce_i;
            for (int i = 1; i < DEPTH; i++) begin
                shift_q[i] <= shift_q[i-1];
            end
        end
    end

    assign sample_valid_o = shift_q[DEPTH-1];

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates BLOCK_LEN adder sums per block and offers the total on a
// valid/ready handshake. MINMAX_TRACK_EN adds per-block min/max tracking.
module adder_sum_accumulator
    import adder_acc_pkg::*;
#(
    parameter int SUM_W     = SUM_W_D,
    parameter int ACC_W     = ACC_W_D,
    parameter int BLOCK_LEN = 8,
    parameter int ADD_LAT   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ce_in,
    input  logic [SUM_W-1:0]        sum_in,
    input  logic                    start,
    output logic                    busy,
    output logic [7:0]              drop_cnt,
    adder_sum_accumulator_if.master rd
);

    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       drop_q, drop_d;

    logic             sample_valid_s;
    logic             accept_s;
    logic             last_s;
    logic             take_s;
    logic             clear_s;
    logic [ACC_W:0]   add_s;

    ce_delay_line #(
        .DEPTH (ADD_LAT)
    ) u_ce_delay (
        .clock          (clock),
        .reset          (reset),
        .ce_i           (ce_in),
        .sample_valid_o (sample_valid_s)
    );

    assign accept_s = (state_q == ACCUM) && sample_valid_s;
    assign last_s   = accept_s && (cnt_q == CNT_LAST);
    assign take_s   = out_valid_q && rd.out_ready;
    assign add_s    = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum_in};
    // Any entry into ACCUM, from IDLE or straight out of HOLD, starts a fresh block
    assign clear_s  = (state_q != ACCUM) && (state_d == ACCUM);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (last_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (take_s) begin
                    state_d = start ? ACCUM : IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d == ACCUM);
        if (clear_s) begin
            acc_d = {ACC_W{1'b0}};
            ovf_d = 1'b0;
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_d = add_s[ACC_W-1:0];
            ovf_d = ovf_q | add_s[ACC_W];
            cnt_d = last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1'b1));
        end else begin
            acc_d = acc_q;
        end
        if (sample_valid_s && (state_q != ACCUM)) begin
            drop_d = sat_inc8(drop_q);
        end else begin
            drop_d = drop_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            drop_q      <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MINMAX_TRACK_EN
    logic [SUM_W-1:0] min_q, min_d;
    logic [SUM_W-1:0] max_q, max_d;

    // Block min/max next values; frozen outside accepted samples
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_s) begin
            min_d = {SUM_W{1'b1}};
            max_d = {SUM_W{1'b0}};
        end else if (accept_s) begin
            min_d = (sum_in < min_q) ? sum_in : min_q;
            max_d = (sum_in > max_q) ? sum_in : max_q;
        end else begin
            min_d = min_q;
        end
    end

    // Block min/max registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= {SUM_W{1'b0}};
            max_q <= {SUM_W{1'b0}};
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign rd.min_out = min_q;
    assign rd.max_out = max_q;
`else
    assign rd.min_out = {SUM_W{1'b0}};
    assign rd.max_out = {SUM_W{1'b0}};
`endif

    assign rd.out_valid = out_valid_q;
    assign rd.acc_out   = acc_q;
    assign rd.overflow  = ovf_q;
    assign busy         = busy_q;
    assign drop_cnt     = drop_q;

endmodule
